axi_lite_mem_responder: RTL and testbench
=========================================

# axi_lite_mem_responder

Synthesizable AXI4-Lite subordinate backed by a word-addressed register array, serving as the responder end of the controller-side write/read traffic the testbench master issues. It accepts independent AW/W/AR channels, commits byte-strobed writes, returns registered read data, and signals out-of-range accesses. It sits behind the shared AXI interface in the hwpe testbench, where it stands in for memory in RTL-only runs without co-simulation.

## Interface
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data width; fixed at 32 (strobe width 4)
- DEPTH, 1024, number of 32-bit words; power of two
- BASE_ADDR, 32'h0, byte address of word 0
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- s_awaddr / s_awprot / s_awvalid  input  ADDR_WIDTH / 3 / 1  write address channel; prot ignored
- s_awready  output  1  write address accepted
- s_wdata / s_wstrb / s_wvalid  input  32 / 4 / 1  write data channel
- s_wready  output  1  write data accepted
- s_bresp  output  2  write response (2'b00 OKAY, 2'b10 SLVERR)
- s_bvalid  output  1  / s_bready  input  1  write response handshake
- s_araddr / s_arprot / s_arvalid  input  ADDR_WIDTH / 3 / 1  read address channel; prot ignored
- s_arready  output  1  read address accepted
- s_rdata  output  32  / s_rresp  output  2  read data and response
- s_rvalid  output  1  / s_rready  input  1  read data handshake

## Operation
- Word index = (addr − BASE_ADDR) >> 2; addr[1:0] ignored (unaligned treated as aligned). In range iff addr ≥ BASE_ADDR and index < DEPTH.
- Write path: one-entry AW holding register and one-entry W holding register, filled independently in any order. s_awready = !reset && !aw_full; s_wready = !reset && !w_full.
- Commit: in a cycle where aw_full && w_full && (!s_bvalid || s_bready): bytes with s_wstrb[i]=1 written at that edge, both holds cleared, s_bvalid=1 and s_bresp set from next cycle. wstrb=4'b0000 commits nothing but still responds OKAY.
- s_bvalid holds with stable s_bresp until s_bready; a new commit in the s_bready cycle reloads s_bvalid back-to-back.
- Read path: s_arready = !reset && (!s_rvalid || s_rready). AR handshake loads s_rdata/s_rresp and sets s_rvalid next cycle; s_rvalid/s_rdata stable until s_rready.
- Read/write channels independent; read and commit to the same word at the same edge: read returns pre-write data.
- Memory contents not reset.

## Timing
- Reset (async assert): s_bvalid=0, s_rvalid=0, s_bresp=0, s_rresp=0, s_rdata=0, all holds empty; all readies 0 while reset high, 1 first cycle after release.
- Reset mid-transaction: buffered AW/W and pending B/R dropped; memory keeps committed data.
- Write latency: AW and W handshaken same edge (cycle 0) → commit edge end of cycle 1 → s_bvalid in cycle 2. Write throughput: one per 2 cycles.
- Read latency: AR handshake at edge of cycle 0 → s_rvalid in cycle 1. Full throughput with s_rready held high.
- Backpressure: B stall blocks commits, holds stay full, s_awready/s_wready stay 0.

## Configuration
- AXI_LITE_MEM_RESP_ERR_EN defined: out-of-range write commits nothing and responds SLVERR; out-of-range read returns s_rdata=32'h0, SLVERR.
- Undefined: range check removed; index taken modulo DEPTH (wraps), all responses OKAY.

## Test plan
- After reset release, write 32'h100 to 32'h10 (strobe 4'hF), read 32'h10 → s_bresp=OKAY in cycle 2, s_rdata=32'h100, s_rresp=OKAY.
- W presented 3 cycles before AW to 32'h20, data 32'hDEADBEEF → s_wready drops after W hold fills, s_bvalid exactly 2 cycles after AW handshake; readback 32'hDEADBEEF.
- Preload 32'hFFFF_FFFF at 32'h4, write 32'h1234_5678 strobe 4'b0101 → readback 32'hFF34_FF78.
- s_bready held low 5 cycles after first write, second AW/W issued → second commit waits, s_bvalid stays 1 with stable s_bresp, second response appears the cycle after first s_bready.
- With macro defined, DEPTH=1024, BASE_ADDR=0: write/read 32'h1000 → SLVERR both, s_rdata=0, word 0 unchanged; without macro, same write lands in word 0, OKAY.
- Assert reset while aw_full and s_rvalid=1 → all valids 0 immediately, readies 0 until release; earlier committed word still reads back intact.

Source files
------------

// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite subordinate backed by a word-addressed byte-strobed register array.
// Define AXI_LITE_MEM_RESP_ERR_EN to enable out-of-range SLVERR checking (default: index wraps modulo DEPTH).
module axi_lite_mem_responder #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [2:0]              s_awprot,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [2:0]              s_arprot,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic                    r_aw_full;
  logic [ADDR_WIDTH-1:0]   r_aw_addr;
  logic                    r_w_full;
  logic [DATA_WIDTH-1:0]   r_w_data;
  logic [STRB_W-1:0]       r_w_strb;
  logic                    r_bvalid;
  logic [1:0]              r_bresp;
  logic                    r_rvalid;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]              r_rresp;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   w_aw_off;
  logic [ADDR_WIDTH-1:0]   w_ar_off;
  logic [IDX_W-1:0]        w_aw_idx;
  logic [IDX_W-1:0]        w_ar_idx;
  logic                    w_aw_ok;
  logic                    w_ar_ok;
  logic                    w_commit;
  logic                    w_ar_hs;
  logic                    w_unused;

  assign w_aw_off = r_aw_addr - BASE_ADDR;
  assign w_ar_off = s_araddr - BASE_ADDR;
  assign w_aw_idx = w_aw_off[IDX_W+1:2];
  assign w_ar_idx = w_ar_off[IDX_W+1:2];

`ifdef AXI_LITE_MEM_RESP_ERR_EN
  assign w_aw_ok = (r_aw_addr >= BASE_ADDR) && ((w_aw_off >> 2) < ADDR_WIDTH'(DEPTH));
  assign w_ar_ok = (s_araddr >= BASE_ADDR) && ((w_ar_off >> 2) < ADDR_WIDTH'(DEPTH));
`else
  assign w_aw_ok = 1'b1;
  assign w_ar_ok = 1'b1;
`endif

  assign w_unused = ^{s_awprot, s_arprot, w_aw_off, w_ar_off};

  assign s_awready = !reset && !r_aw_full;
  assign s_wready  = !reset && !r_w_full;
  assign s_arready = !reset && (!r_rvalid || s_rready);
  assign w_commit  = r_aw_full && r_w_full && (!r_bvalid || s_bready);
  assign w_ar_hs   = s_arvalid && s_arready;

  assign s_bvalid = r_bvalid;
  assign s_bresp  = r_bresp;
  assign s_rvalid = r_rvalid;
  assign s_rdata  = r_rdata;
  assign s_rresp  = r_rresp;

  // Holds cannot fill and commit in the same cycle since readiness requires an empty hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      if (s_awvalid && s_awready) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= s_awaddr;
      end
      if (s_wvalid && s_wready) begin
        r_w_full <= 1'b1;
        r_w_data <= s_wdata;
        r_w_strb <= s_wstrb;
      end
      if (w_commit) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_aw_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (r_bvalid && s_bready) begin
        r_bvalid <= 1'b0;
      end
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_ar_ok ? r_mem[w_ar_idx] : '0;
        r_rresp  <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (r_rvalid && s_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Storage is deliberately outside the reset domain so committed data survives reset.
  always_ff @(posedge clk) begin
    if (w_commit && w_aw_ok) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (r_w_strb[i]) begin
          r_mem[w_aw_idx][8*i +: 8] <= r_w_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Directed self-checking bench for axi_lite_mem_responder; honours AXI_LITE_MEM_RESP_ERR_EN.
module tb_axi_lite_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_awaddr;
  logic [2:0]  s_awprot;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [31:0] s_araddr;
  logic [2:0]  s_arprot;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_lite_mem_responder #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (1024),
    .BASE_ADDR  (32'h0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_awaddr  (s_awaddr),
    .s_awprot  (s_awprot),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_araddr  (s_araddr),
    .s_arprot  (s_arprot),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] st, output logic [1:0] resp);
    int cyc;
    int lat;
    s_awaddr  = a;
    s_wdata   = d;
    s_wstrb   = st;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
    s_bready  = 1'b1;
    cyc = 0;
    while (!(s_awready && s_wready) && cyc < 20) begin
      tick();
      cyc++;
    end
    check_eq({tag, "_wr_hs"}, 32'(s_awready && s_wready), 32'd1);
    tick();
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    lat = 1;
    while (!s_bvalid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq({tag, "_b_cycle"}, 32'(lat), 32'd2);
    resp = s_bresp;
    tick();
  endtask

  task automatic do_read(input string tag, input logic [31:0] a,
                         output logic [31:0] data, output logic [1:0] resp);
    int cyc;
    s_araddr  = a;
    s_arvalid = 1'b1;
    s_rready  = 1'b1;
    cyc = 0;
    while (!s_arready && cyc < 20) begin
      tick();
      cyc++;
    end
    check_eq({tag, "_ar_hs"}, 32'(s_arready), 32'd1);
    tick();
    s_arvalid = 1'b0;
    check_eq({tag, "_rvalid"}, 32'(s_rvalid), 32'd1);
    data = s_rdata;
    resp = s_rresp;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    logic [1:0]  rr;

    reset = 1'b1;
    s_awaddr = '0; s_awprot = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_araddr = '0; s_arprot = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    repeat (3) tick();

    check_eq("rst_bvalid", 32'(s_bvalid), 32'd0);
    check_eq("rst_rvalid", 32'(s_rvalid), 32'd0);
    check_eq("rst_bresp", 32'(s_bresp), 32'd0);
    check_eq("rst_rresp", 32'(s_rresp), 32'd0);
    check_eq("rst_rdata", s_rdata, 32'h0);
    check_eq("rst_readies", {29'b0, s_awready, s_wready, s_arready}, 32'd0);
    reset = 1'b0;
    tick();
    check_eq("rel_readies", {29'b0, s_awready, s_wready, s_arready}, 32'd7);

    // Basic write then read
    do_write("t1", 32'h10, 32'h100, 4'hF, resp);
    check_eq("t1_bresp", 32'(resp), 32'd0);
    do_read("t1", 32'h10, rd, rr);
    check_eq("t1_rdata", rd, 32'h100);
    check_eq("t1_rresp", 32'(rr), 32'd0);

    // W leads AW by three cycles
    s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b1;
    check_eq("t2_wready_pre", 32'(s_wready), 32'd1);
    tick();
    s_wvalid = 1'b0;
    check_eq("t2_wready_drop", 32'(s_wready), 32'd0);
    tick();
    tick();
    check_eq("t2_wready_held", 32'(s_wready), 32'd0);
    check_eq("t2_bvalid_early", 32'(s_bvalid), 32'd0);
    s_awaddr = 32'h20; s_awvalid = 1'b1;
    check_eq("t2_awready", 32'(s_awready), 32'd1);
    tick();
    s_awvalid = 1'b0;
    check_eq("t2_bvalid_c1", 32'(s_bvalid), 32'd0);
    tick();
    check_eq("t2_bvalid_c2", 32'(s_bvalid), 32'd1);
    check_eq("t2_bresp", 32'(s_bresp), 32'd0);
    tick();
    check_eq("t2_wready_back", 32'(s_wready), 32'd1);
    do_read("t2", 32'h20, rd, rr);
    check_eq("t2_rdata", rd, 32'hDEADBEEF);

    // Byte strobes
    do_write("t3a", 32'h4, 32'hFFFF_FFFF, 4'hF, resp);
    do_write("t3b", 32'h4, 32'h1234_5678, 4'b0101, resp);
    do_read("t3", 32'h4, rd, rr);
    check_eq("t3_rdata", rd, 32'hFF34_FF78);

    // B backpressure blocks the second commit
    s_bready = 1'b0;
    s_awaddr = 32'h30; s_wdata = 32'h1111_1111; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    tick();
    check_eq("t4_b1_valid", 32'(s_bvalid), 32'd1);
    s_awaddr = 32'h34; s_wdata = 32'h2222_2222;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("t4_stall_bvalid", 32'(s_bvalid), 32'd1);
      check_eq("t4_stall_bresp", 32'(s_bresp), 32'd0);
      check_eq("t4_stall_readies", {30'b0, s_awready, s_wready}, 32'd0);
      tick();
    end
    s_bready = 1'b1;
    tick();
    check_eq("t4_b2_valid", 32'(s_bvalid), 32'd1);
    check_eq("t4_b2_readies", {30'b0, s_awready, s_wready}, 32'd3);
    tick();
    check_eq("t4_b2_done", 32'(s_bvalid), 32'd0);
    do_read("t4a", 32'h30, rd, rr);
    check_eq("t4_rdata1", rd, 32'h1111_1111);
    do_read("t4b", 32'h34, rd, rr);
    check_eq("t4_rdata2", rd, 32'h2222_2222);

    // Out-of-range access at one word past the array
    do_write("t5a", 32'h0, 32'h0BAD_F00D, 4'hF, resp);
    do_write("t5b", 32'h1000, 32'hA5A5_A5A5, 4'hF, resp);
`ifdef AXI_LITE_MEM_RESP_ERR_EN
    check_eq("t5_bresp", 32'(resp), 32'd2);
    do_read("t5a", 32'h1000, rd, rr);
    check_eq("t5_oor_rdata", rd, 32'h0);
    check_eq("t5_oor_rresp", 32'(rr), 32'd2);
    do_read("t5b", 32'h0, rd, rr);
    check_eq("t5_word0", rd, 32'h0BAD_F00D);
`else
    check_eq("t5_bresp", 32'(resp), 32'd0);
    do_read("t5a", 32'h1000, rd, rr);
    check_eq("t5_wrap_rdata", rd, 32'hA5A5_A5A5);
    check_eq("t5_wrap_rresp", 32'(rr), 32'd0);
    do_read("t5b", 32'h0, rd, rr);
    check_eq("t5_word0", rd, 32'hA5A5_A5A5);
`endif

    // Reset with AW buffered and a read response pending
    do_write("t6", 32'h40, 32'hCAFE_F00D, 4'hF, resp);
    s_awaddr = 32'h44; s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    check_eq("t6_aw_full", 32'(s_awready), 32'd0);
    s_araddr = 32'h40; s_arvalid = 1'b1; s_rready = 1'b0;
    tick();
    s_arvalid = 1'b0;
    check_eq("t6_rvalid_pre", 32'(s_rvalid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("t6_rst_valids", {30'b0, s_bvalid, s_rvalid}, 32'd0);
    check_eq("t6_rst_readies", {29'b0, s_awready, s_wready, s_arready}, 32'd0);
    check_eq("t6_rst_rdata", s_rdata, 32'h0);
    tick();
    check_eq("t6_rst_readies2", {29'b0, s_awready, s_wready, s_arready}, 32'd0);
    reset = 1'b0;
    tick();
    check_eq("t6_rel_readies", {29'b0, s_awready, s_wready, s_arready}, 32'd7);
    s_wdata = 32'h0000_0099; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b1;
    tick();
    s_wvalid = 1'b0;
    tick();
    tick();
    check_eq("t6_aw_dropped", 32'(s_bvalid), 32'd0);
    s_awaddr = 32'h48; s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    tick();
    check_eq("t6_b_after", 32'(s_bvalid), 32'd1);
    tick();
    do_read("t6a", 32'h40, rd, rr);
    check_eq("t6_kept", rd, 32'hCAFE_F00D);
    do_read("t6b", 32'h48, rd, rr);
    check_eq("t6_new", rd, 32'h0000_0099);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
